// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-lane data memory and its dump engine.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    SEND = 2'b10,
    DONE = 2'b11
  } dump_state_e;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      default: return (lane == 2'b00);
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_dump_fsm.sv
// Dump sequencer: walks word indices 0..dump_words-1, issuing one
// second-port read per word and holding each word until it is accepted.
//
//   state | meaning
//   IDLE  | waiting for dump_start
//   RD    | second-port read of word idx
//   SEND  | word idx presented, waiting for ready
//   DONE  | one-cycle completion pulse
module mem_dump_fsm
  import data_mem_pkg::*;
#(
  parameter int ram_depth  = 2048,
  parameter int dump_words = 2048,
  localparam int AW = $clog2(ram_depth)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          ready_i,
  output logic          rd_en_o,
  output logic [AW-1:0] idx_o,
  output logic          valid_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(dump_words - 1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // State and index registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RD;
        idx_d   = '0;
      end
      RD: state_d = SEND;
      SEND: if (ready_i) begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    rd_en_o = (state_q == RD);
    valid_o = (state_q == SEND);
    done_o  = (state_q == DONE);
    busy_o  = (state_q != IDLE);
    idx_o   = idx_q;
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// MEM-stage data memory: byte-lane stores, extending loads with a
// one-cycle registered read, misalignment flag and a read-only dump port.
module data_mem_bytelane
  import data_mem_pkg::*;
#(
  parameter int len_addr   = 32,
  parameter int len_data   = 32,
  parameter int ram_depth  = 2048,
  parameter int dump_words = 2048,
  localparam int AW = $clog2(ram_depth)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [len_addr-1:0] addr,
  input  logic [len_data-1:0] wr_data,
  output logic [len_data-1:0] rd_data,
  output logic                rd_valid,
  output logic                misaligned,
  input  logic                dump_start,
  input  logic                dump_ready,
  output logic                dump_valid,
  output logic [AW-1:0]       dump_addr,
  output logic [len_data-1:0] dump_data,
  output logic                dump_busy,
  output logic                dump_done
);

  logic [len_data-1:0] mem_q [ram_depth];

  logic [AW-1:0]       widx;
  logic [1:0]          lane;
  logic                aligned, wr_ok, rd_ok, mis_d;
  logic [LANES-1:0]    we;
  logic [len_data-1:0] wr_lanes, rd_word, rd_ext, rd_data_d;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic                addr_unused;

  logic [len_data-1:0] rd_data_q, dump_data_q;
  logic                rd_valid_q, mis_q;
  logic                dump_rd_en;
  logic [AW-1:0]       dump_idx;

  // Upper address bits fold away: the word index wraps modulo ram_depth.
  assign addr_unused = ^addr[len_addr-1:AW+2];
  assign widx        = addr[AW+1:2];
  assign lane        = addr[1:0];
  assign aligned     = is_aligned(mem_size, lane);
  assign wr_ok       = mem_wr & aligned & ~reset;
  assign rd_ok       = mem_rd & ~mem_wr & aligned;
  assign mis_d       = (mem_rd | mem_wr) & ~aligned;
  assign rd_word     = mem_q[widx];

  // Replicate store data across lanes so each enabled lane picks its slice.
  always_comb begin
    we = wr_ok ? lane_enables(mem_size, lane) : '0;
    case (mem_size)
      SZ_BYTE: wr_lanes = {4{wr_data[7:0]}};
      SZ_HALF: wr_lanes = {2{wr_data[15:0]}};
      default: wr_lanes = wr_data;
    endcase
  end

  // Lane extraction and sign/zero extension of the pre-write word.
  always_comb begin
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (mem_size)
      SZ_BYTE: rd_ext = {{24{ld_byte[7] & ~mem_unsigned}}, ld_byte};
      SZ_HALF: rd_ext = {{16{ld_half[15] & ~mem_unsigned}}, ld_half};
      default: rd_ext = rd_word;
    endcase
    rd_data_d = rd_ok ? rd_ext : rd_data_q;
  end

  // RAM array: per-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem_q[widx][8*l +: 8] <= wr_lanes[8*l +: 8];
    end
  end

  // CPU-port load result and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_ok;
      mis_q      <= mis_d;
    end
  end

  // Second read port, sampled in the dump RD cycle (read-first vs CPU stores).
  always_ff @(posedge clk) begin
    if (reset) dump_data_q <= '0;
    else if (dump_rd_en) dump_data_q <= mem_q[dump_idx];
  end

  mem_dump_fsm #(
    .ram_depth (ram_depth),
    .dump_words(dump_words)
  ) u_dump (
    .clk_i  (clk),
    .reset_i(reset),
    .start_i(dump_start),
    .ready_i(dump_ready),
    .rd_en_o(dump_rd_en),
    .idx_o  (dump_idx),
    .valid_o(dump_valid),
    .busy_o (dump_busy),
    .done_o (dump_done)
  );

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign misaligned = mis_q;
  assign dump_addr  = dump_idx;
  assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
module tb_data_mem_bytelane;
  import data_mem_pkg::*;

  localparam int AW = 11;

  logic          clk, reset, mem_rd, mem_wr, mem_unsigned;
  logic [1:0]    mem_size;
  logic [31:0]   addr, wr_data, rd_data, dump_data;
  logic          rd_valid, misaligned;
  logic          dump_start, dump_ready, dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd = '0;

  data_mem_bytelane #(
    .len_addr(32), .len_data(32), .ram_depth(2048), .dump_words(4)
  ) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .misaligned(misaligned), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU-port cycle; loads that should produce data go to the scoreboard.
  task automatic cpu(input string tag, input logic rd, input logic wr,
                     input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] d, input logic emis, input logic [31:0] edata);
    logic [31:0] e;
    mem_rd = rd; mem_wr = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; wr_data = d;
    if (rd && !wr && !emis) sb_q.push_back(edata);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    chk({tag, " misaligned"}, 64'(misaligned), 64'(emis));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
      chk({tag, " rd_data"}, 64'(rd_data), 64'(e));
      last_rd = e;
    end else begin
      chk({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
      chk({tag, " rd_data hold"}, 64'(rd_data), 64'(last_rd));
    end
  endtask

  // Runs a dump of words 0..3 (expected 1,2,3,4); optional stall and abort.
  task automatic do_dump(input string tag, input int stall_at, input int stall_len,
                         input int abort_at);
    logic [31:0] dq[$];
    int exp_idx = 0;
    int stalls  = 0;
    bit fin     = 1'b0;
    dq = '{32'd1, 32'd2, 32'd3, 32'd4};
    dump_start = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy"}, 64'(dump_busy), 64'd1);
    // start is kept high during the dump; it must be ignored outside IDLE
    for (int c = 0; c < 40 && !fin; c++) begin
      dump_ready = 1'b0;
      if (dump_done) begin
        fin = 1'b1;
        dump_start = 1'b0;
        chk({tag, " words left"}, 64'(dq.size()), 64'd0);
      end else if (dump_valid) begin
        chk({tag, " addr"}, 64'(dump_addr), 64'(exp_idx));
        chk({tag, " data"}, 64'(dump_data), 64'(dq.size() > 0 ? dq[0] : 32'hDEAD_BEEF));
        if (exp_idx == abort_at) begin
          dump_start = 1'b0;
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          chk({tag, " abort valid"}, 64'(dump_valid), 64'd0);
          chk({tag, " abort busy"}, 64'(dump_busy), 64'd0);
          chk({tag, " abort done"}, 64'(dump_done), 64'd0);
          chk({tag, " abort addr"}, 64'(dump_addr), 64'd0);
          chk({tag, " abort data"}, 64'(dump_data), 64'd0);
          @(posedge clk); #1;
          chk({tag, " no late done"}, 64'(dump_done), 64'd0);
          sb_q.delete();
          last_rd = '0;
          return;
        end
        if (exp_idx == stall_at && stalls < stall_len) begin
          stalls++;
        end else begin
          dump_ready = 1'b1;
          void'(dq.pop_front());
          exp_idx++;
        end
      end
      @(posedge clk); #1;
    end
    dump_start = 1'b0;
    dump_ready = 1'b0;
    chk({tag, " done seen"}, 64'(fin), 64'd1);
    chk({tag, " done pulse end"}, 64'(dump_done), 64'd0);
    chk({tag, " busy after"}, 64'(dump_busy), 64'd0);
    chk({tag, " valid after"}, 64'(dump_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = SZ_WORD;
    mem_unsigned = 1'b0; addr = '0; wr_data = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rd_data", 64'(rd_data), 64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst misaligned", 64'(misaligned), 64'd0);
    chk("rst dump_valid", 64'(dump_valid), 64'd0);
    chk("rst dump_addr", 64'(dump_addr), 64'd0);
    chk("rst dump_data", 64'(dump_data), 64'd0);
    chk("rst dump_busy", 64'(dump_busy), 64'd0);
    chk("rst dump_done", 64'(dump_done), 64'd0);
    reset = 1'b0;

    cpu("sw 10",    0, 1, SZ_WORD, 0, 32'h10, 32'h8000_00FF, 0, 0);
    cpu("lw 10",    1, 0, SZ_WORD, 0, 32'h10, 0, 0, 32'h8000_00FF);
    cpu("idle",     0, 0, SZ_WORD, 0, 32'h10, 0, 0, 0);
    cpu("sw 10b",   0, 1, SZ_WORD, 0, 32'h10, 32'h1122_3344, 0, 0);
    cpu("sb 13",    0, 1, SZ_BYTE, 0, 32'h13, 32'hFFFF_FFAB, 0, 0);
    cpu("lw sb",    1, 0, SZ_WORD, 0, 32'h10, 0, 0, 32'hAB22_3344);
    cpu("lb 13",    1, 0, SZ_BYTE, 0, 32'h13, 0, 0, 32'hFFFF_FFAB);
    cpu("lbu 13",   1, 0, SZ_BYTE, 1, 32'h13, 0, 0, 32'h0000_00AB);
    cpu("lb 11",    1, 0, SZ_BYTE, 0, 32'h11, 0, 0, 32'h0000_0033);
    cpu("sh 12",    0, 1, SZ_HALF, 0, 32'h12, 32'hFFFF_8001, 0, 0);
    cpu("lh 12",    1, 0, SZ_HALF, 0, 32'h12, 0, 0, 32'hFFFF_8001);
    cpu("lhu 12",   1, 0, SZ_HALF, 1, 32'h12, 0, 0, 32'h0000_8001);
    cpu("lh 10",    1, 0, SZ_HALF, 0, 32'h10, 0, 0, 32'h0000_3344);
    cpu("sh 11 mis",0, 1, SZ_HALF, 0, 32'h11, 32'h0000_5555, 1, 0);
    cpu("lw nochg", 1, 0, SZ_WORD, 0, 32'h10, 0, 0, 32'h8001_3344);
    cpu("lw 12 mis",1, 0, SZ_WORD, 0, 32'h12, 0, 1, 0);
    cpu("rdwr 14",  1, 1, SZ_WORD, 0, 32'h14, 32'h55AA_55AA, 0, 0);
    cpu("lw 14",    1, 0, SZ_WORD, 0, 32'h14, 0, 0, 32'h55AA_55AA);
    cpu("rsv lw",   1, 0, 2'b11,   0, 32'h14, 0, 0, 32'h55AA_55AA);
    cpu("rsv mis",  1, 0, 2'b11,   0, 32'h15, 0, 1, 0);
    cpu("sw wrap",  0, 1, SZ_WORD, 0, 32'h0000_2008, 32'hCAFE_F00D, 0, 0);
    cpu("lw 8",     1, 0, SZ_WORD, 0, 32'h08, 0, 0, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++)
      cpu("sw dump", 0, 1, SZ_WORD, 0, 32'(4 * i), 32'(i + 1), 0, 0);

    do_dump("dump stall", 1, 3, -1);
    do_dump("dump abort", -1, 0, 2);
    do_dump("dump again", -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
